// File: rtl/shared_mul_scheduler.sv
// Shares one pipelined complex multiplier between 4 requesters. Responses are tagged with the requester ID.
// Define SCHED_FIXED_PRIO_EN for fixed priority (requester 0 highest). Otherwise arbitration is round-robin.
module shared_mul_scheduler #(
   parameter int p_inputWidth    = 8,
   parameter int p_PointPosition = 3,
   parameter int p_mulLatency    = 3
) (
   input  logic                                           CLK,
   input  logic                                           RST,
   input  logic                                           i_enable,
   input  logic [3:0]                                     i_req_valid,
   output logic [3:0]                                     o_req_ready,
   input  logic [4*2*p_inputWidth-1:0]                    i_req_a,
   input  logic [4*2*p_inputWidth-1:0]                    i_req_b,
   output logic                                           o_mul_valid,
   output logic [2*p_inputWidth-1:0]                      o_mul_a,
   output logic [2*p_inputWidth-1:0]                      o_mul_b,
   input  logic signed [2*p_inputWidth-p_PointPosition:0] i_mul_re,
   input  logic signed [2*p_inputWidth-p_PointPosition:0] i_mul_im,
   output logic                                           o_rsp_valid,
   output logic [1:0]                                     o_rsp_id,
   output logic signed [2*p_inputWidth-p_PointPosition:0] o_rsp_re,
   output logic signed [2*p_inputWidth-p_PointPosition:0] o_rsp_im,
   output logic                                           o_idle
);

   localparam int OW = 2*p_inputWidth;
   localparam int MW = 2*p_inputWidth - p_PointPosition + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [1:0]          ptr_q;
   logic [3:0]          grant;
   logic [1:0]          grant_id;
   logic [1:0]          idx;
   logic                found;
   logic                in_flight;

   logic                vld_p0;
   logic [1:0]          id_p0;
   logic [OW-1:0]       mul_a_p0;
   logic [OW-1:0]       mul_b_p0;

   logic [p_mulLatency-1:0] vld_p1;
   logic [1:0]              id_p1 [p_mulLatency];

   logic                vld_p2;
   logic [1:0]          id_p2;
   logic signed [MW-1:0] re_p2;
   logic signed [MW-1:0] im_p2;

   // Arbitration: first valid requester at or after the pointer, only while running and enabled
   always_comb begin
      grant    = '0;
      grant_id = '0;
      found    = 1'b0;
      idx      = '0;
      if (state_q == S_RUN && i_enable && !RST) begin
         for (int i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!found && i_req_valid[idx]) begin
               found       = 1'b1;
               grant_id    = idx;
               grant[idx]  = 1'b1;
            end
         end
      end
   end

   assign o_req_ready = grant;

`ifdef SCHED_FIXED_PRIO_EN
   always_ff @(posedge CLK) begin
      ptr_q <= '0;
   end
`else
   always_ff @(posedge CLK) begin
      if (RST) begin
         ptr_q <= '0;
      end else if (found) begin
         ptr_q <= grant_id + 2'd1;
      end
   end
`endif

   // Stage p0: registered operands presented to the multiplier
   always_ff @(posedge CLK) begin
      if (RST) begin
         vld_p0   <= 1'b0;
         id_p0    <= '0;
         mul_a_p0 <= '0;
         mul_b_p0 <= '0;
      end else begin
         vld_p0 <= found;
         if (found) begin
            id_p0    <= grant_id;
            mul_a_p0 <= i_req_a[int'(grant_id)*OW +: OW];
            mul_b_p0 <= i_req_b[int'(grant_id)*OW +: OW];
         end
      end
   end

   assign o_mul_valid = vld_p0;
   assign o_mul_a     = mul_a_p0;
   assign o_mul_b     = mul_b_p0;

   // Stage p1: tag pipe tracking the multiplier latency
   always_ff @(posedge CLK) begin
      if (RST) begin
         vld_p1 <= '0;
      end else begin
         vld_p1[0] <= vld_p0;
         for (int i = 1; i < p_mulLatency; i++) begin
            vld_p1[i] <= vld_p1[i-1];
         end
      end
   end

   always_ff @(posedge CLK) begin
      id_p1[0] <= id_p0;
      for (int i = 1; i < p_mulLatency; i++) begin
         id_p1[i] <= id_p1[i-1];
      end
   end

   // Stage p2: capture the product that lines up with the oldest tag
   always_ff @(posedge CLK) begin
      if (RST) begin
         vld_p2 <= 1'b0;
         id_p2  <= '0;
         re_p2  <= '0;
         im_p2  <= '0;
      end else begin
         vld_p2 <= vld_p1[p_mulLatency-1];
         if (vld_p1[p_mulLatency-1]) begin
            id_p2 <= id_p1[p_mulLatency-1];
            re_p2 <= i_mul_re;
            im_p2 <= i_mul_im;
         end
      end
   end

   assign o_rsp_valid = vld_p2;
   assign o_rsp_id    = id_p2;
   assign o_rsp_re    = re_p2;
   assign o_rsp_im    = im_p2;

   assign in_flight = vld_p0 | (|vld_p1);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (i_enable) state_d = S_RUN;
         S_RUN:   if (!i_enable) state_d = S_DRAIN;
         S_DRAIN: begin
            if (i_enable) begin
               state_d = S_RUN;
            end else if (!in_flight) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign o_idle = (state_q == S_IDLE);

endmodule

// File: tb/tb_shared_mul_scheduler.sv
// Scoreboard bench for shared_mul_scheduler: random requests, a reference arbiter, and a behavioural multiplier.
module tb_shared_mul_scheduler;
   localparam int W  = 8;
   localparam int PP = 3;
   localparam int L  = 3;
   localparam int OW = 2*W;
   localparam int MW = 2*W - PP + 1;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 en  = 1'b0;
   logic [3:0]           req_valid = '0;
   logic [3:0]           req_ready;
   logic [4*OW-1:0]      req_a = '0;
   logic [4*OW-1:0]      req_b = '0;
   logic                 mul_valid;
   logic [OW-1:0]        mul_a, mul_b;
   logic signed [MW-1:0] mul_re = '0;
   logic signed [MW-1:0] mul_im = '0;
   logic                 rsp_valid;
   logic [1:0]           rsp_id;
   logic signed [MW-1:0] rsp_re, rsp_im;
   logic                 idle;

   int          total = 0;
   int          bad   = 0;
   logic [29:0] exp_q[$];
   int          m_ptr = 0;
   bit          m_run = 1'b0;
   int          run_len = 0;
   int          max_run = 0;
   int          n_grant[4];
   logic [27:0] mpipe[L];

   always #5 clk = ~clk;

   shared_mul_scheduler #(
      .p_inputWidth(W), .p_PointPosition(PP), .p_mulLatency(L)
   ) dut (
      .CLK(clk), .RST(rst), .i_enable(en),
      .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_req_a(req_a), .i_req_b(req_b),
      .o_mul_valid(mul_valid), .o_mul_a(mul_a), .o_mul_b(mul_b),
      .i_mul_re(mul_re), .i_mul_im(mul_im),
      .o_rsp_valid(rsp_valid), .o_rsp_id(rsp_id), .o_rsp_re(rsp_re), .o_rsp_im(rsp_im),
      .o_idle(idle)
   );

   function automatic logic [27:0] cmul(input logic [15:0] a, input logic [15:0] b);
      logic signed [7:0] ar, ai, br, bi;
      int re, im;
      logic [31:0] ru, iu;
      ar = a[15:8]; ai = a[7:0]; br = b[15:8]; bi = b[7:0];
      re = (int'(ar)*int'(br) - int'(ai)*int'(bi)) >>> 3;
      im = (int'(ar)*int'(bi) + int'(ai)*int'(br)) >>> 3;
      ru = re; iu = im;
      return {ru[13:0], iu[13:0]};
   endfunction

   // Behavioural multiplier: the product of the operands seen in cycle c appears in cycle c+L
   always @(negedge clk) begin
      mpipe[0] <= cmul(mul_a, mul_b);
      for (int i = 1; i < L; i++) mpipe[i] <= mpipe[i-1];
      {mul_re, mul_im} <= mpipe[L-1];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (rsp_valid) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rsp_unexpected: got id=%0d re=%0d im=%0d, required no response",
                     rsp_id, rsp_re, rsp_im);
         end else begin
            chk("rsp", {2'b00, rsp_id, rsp_re, rsp_im}, {2'b00, exp_q.pop_front()});
         end
         run_len++;
         if (run_len > max_run) max_run = run_len;
      end else begin
         run_len = 0;
      end
   end

   task automatic rnd_data();
      for (int i = 0; i < 4; i++) begin
         req_a[i*OW +: OW] = 16'($urandom);
         req_b[i*OW +: OW] = 16'($urandom);
      end
   endtask

   // One clock of stimulus; the reference model predicts the grant and queues the response
   task automatic cyc(input logic [3:0] v, input logic e, input logic r);
      logic [3:0] g;
      int k, win;
      req_valid = v; en = e; rst = r;
      #1;
      g = '0; win = -1;
      if (!r && m_run && e) begin
         for (int i = 0; i < 4; i++) begin
            k = (m_ptr + i) % 4;
            if (win < 0 && v[k]) win = k;
         end
      end
      if (win >= 0) g[win] = 1'b1;
      chk("ready", {28'd0, req_ready}, {28'd0, g});
      if (win >= 0) begin
         exp_q.push_back({2'(win), cmul(req_a[win*OW +: OW], req_b[win*OW +: OW])});
         n_grant[win]++;
`ifdef SCHED_FIXED_PRIO_EN
         m_ptr = 0;
`else
         m_ptr = (win + 1) % 4;
`endif
      end
      @(posedge clk);
      m_run = e && !r;
      if (r) begin
         exp_q.delete();
         m_ptr = 0;
      end
      @(negedge clk);
   endtask

   initial begin
      int lat, n;
      @(negedge clk);
      for (int i = 0; i < 3; i++) cyc(4'b1111, 1'b1, 1'b1);
      chk("rst_idle", {31'd0, idle}, 32'd1);
      chk("rst_mul_valid", {31'd0, mul_valid}, 32'd0);
      chk("rst_mul_a", {16'd0, mul_a}, 32'd0);
      chk("rst_mul_b", {16'd0, mul_b}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_data", {2'b00, rsp_id, rsp_re, rsp_im}, 32'd0);

      // Single request with known operands: latency and product
      cyc(4'b0000, 1'b1, 1'b0);
      req_a[15:0] = 16'h0800;
      req_b[15:0] = 16'h1008;
      cyc(4'b0001, 1'b1, 1'b0);
      lat = 1;
      while (!rsp_valid && lat < 20) begin
         cyc(4'b0000, 1'b1, 1'b0);
         lat++;
      end
      chk("latency", lat, 5);
      chk("t1_id", {30'd0, rsp_id}, 32'd0);
      chk("t1_re", 32'(rsp_re), 32'd16);
      chk("t1_im", 32'(rsp_im), 32'd8);
      for (int i = 0; i < 6; i++) cyc(4'b0000, 1'b1, 1'b0);

      // All requesters valid: one grant per cycle, responses back to back
      max_run = 0;
      for (int i = 0; i < 16; i++) begin rnd_data(); cyc(4'b1111, 1'b1, 1'b0); end
      for (int i = 0; i < 8; i++) cyc(4'b0000, 1'b1, 1'b0);
      chk("t2_no_gaps", max_run, 16);

      // Only requester 2 valid, then check where the pointer was left
      for (int i = 0; i < 4; i++) begin rnd_data(); cyc(4'b0100, 1'b1, 1'b0); end
      req_valid = 4'b1111;
      #1;
`ifdef SCHED_FIXED_PRIO_EN
      chk("t3_next_grant", {28'd0, req_ready}, 32'h1);
`else
      chk("t3_next_grant", {28'd0, req_ready}, 32'h8);
`endif
      cyc(4'b1111, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) cyc(4'b0000, 1'b1, 1'b0);

      // Drain on enable drop, then re-enable during drain
      for (int i = 0; i < 4; i++) begin rnd_data(); cyc(4'b1111, 1'b1, 1'b0); end
      cyc(4'b1111, 1'b0, 1'b0);
      chk("t4_drain_busy", {31'd0, idle}, 32'd0);
      n = 0;
      while (!idle && n < 20) begin cyc(4'b1111, 1'b0, 1'b0); n++; end
      chk("t4_idle_after_drain", {31'd0, idle}, 32'd1);
      chk("t4_all_rsp", exp_q.size(), 0);
      cyc(4'b0000, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) begin rnd_data(); cyc(4'b1111, 1'b1, 1'b0); end
      cyc(4'b1111, 1'b0, 1'b0);
      cyc(4'b1111, 1'b1, 1'b0);
      chk("t4_rerun_idle", {31'd0, idle}, 32'd0);
      rnd_data(); cyc(4'b1111, 1'b1, 1'b0);
      chk("t4_rerun_idle2", {31'd0, idle}, 32'd0);
      for (int i = 0; i < 8; i++) cyc(4'b0000, 1'b1, 1'b0);

      // Reset with transactions in flight
      for (int i = 0; i < 3; i++) begin rnd_data(); cyc(4'b1111, 1'b1, 1'b0); end
      cyc(4'b0000, 1'b0, 1'b1);
      chk("t5_idle", {31'd0, idle}, 32'd1);
      chk("t5_mul_valid", {31'd0, mul_valid}, 32'd0);
      chk("t5_mul_a", {16'd0, mul_a}, 32'd0);
      chk("t5_rsp", {1'b0, rsp_valid, rsp_id, rsp_re, rsp_im}, 32'd0);
      for (int i = 0; i < 8; i++) cyc(4'b0000, 1'b0, 1'b0);

      // Requesters 0 and 3 always valid
      cyc(4'b0000, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) n_grant[i] = 0;
      for (int i = 0; i < 10; i++) begin rnd_data(); cyc(4'b1001, 1'b1, 1'b0); end
`ifdef SCHED_FIXED_PRIO_EN
      chk("t6_grant0", n_grant[0], 10);
      chk("t6_grant3", n_grant[3], 0);
`else
      chk("t6_grant0", n_grant[0], 5);
      chk("t6_grant3", n_grant[3], 5);
`endif

      // Random traffic with enable toggling and occasional reset
      for (int i = 0; i < 400; i++) begin
         rnd_data();
         cyc(4'($urandom), 1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 99) == 0));
      end

      n = 0;
      while (exp_q.size() != 0 && n < 30) begin cyc(4'b0000, 1'b0, 1'b0); n++; end
      chk("final_drain", exp_q.size(), 0);
      for (int i = 0; i < 4; i++) cyc(4'b0000, 1'b0, 1'b0);
      chk("final_idle", {31'd0, idle}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
